// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and types for the seven-segment readback block.
//   - SEG_0..SEG_F : segment patterns (a..g in bits 7..1, dp in bit 0 = 0)
//   - SEG_BLANK    : all segments off
//   - SEG_DP_MASK  : keeps a..g, drops the decimal point
//   - state_t      : IDLE (nothing committed since reset) / TRACK
package seg_pkg;

    localparam logic [7:0] SEG_0 = 8'hFC;
    localparam logic [7:0] SEG_1 = 8'h60;
    localparam logic [7:0] SEG_2 = 8'hDA;
    localparam logic [7:0] SEG_3 = 8'hF2;
    localparam logic [7:0] SEG_4 = 8'h66;
    localparam logic [7:0] SEG_5 = 8'hB6;
    localparam logic [7:0] SEG_6 = 8'hBE;
    localparam logic [7:0] SEG_7 = 8'hE0;
    localparam logic [7:0] SEG_8 = 8'hFE;
    localparam logic [7:0] SEG_9 = 8'hF6;
    localparam logic [7:0] SEG_A = 8'hEE;
    localparam logic [7:0] SEG_B = 8'h3E;
    localparam logic [7:0] SEG_C = 8'h9C;
    localparam logic [7:0] SEG_D = 8'h7A;
    localparam logic [7:0] SEG_E = 8'h9E;
    localparam logic [7:0] SEG_F = 8'h8E;

    localparam logic [7:0] SEG_BLANK   = 8'h00;
    localparam logic [7:0] SEG_DP_MASK = 8'hFE;

    typedef enum logic {
        IDLE  = 1'b0,
        TRACK = 1'b1
    } state_t;

endpackage

// File: rtl/seg_byte_decode.sv
// seg_byte_decode: combinational decode of one seven-segment byte.
//   seg_byte [7:0] in  : a..g in bits 7..1, dp in bit 0 (ignored)
//   legal          out : byte is one of the 16 hex digit patterns
//   blank          out : byte is all segments off
//   nibble   [3:0] out : decoded hex value (0 when not legal)
module seg_byte_decode
    import seg_pkg::*;
(
    input  logic [7:0] seg_byte,
    output logic       legal,
    output logic       blank,
    output logic [3:0] nibble
);

    logic [7:0] masked;

    always_comb begin
        masked = seg_byte & SEG_DP_MASK;
        legal  = 1'b1;
        nibble = 4'h0;
        blank  = (masked == SEG_BLANK);
        case (masked)
            SEG_0:   nibble = 4'h0;
            SEG_1:   nibble = 4'h1;
            SEG_2:   nibble = 4'h2;
            SEG_3:   nibble = 4'h3;
            SEG_4:   nibble = 4'h4;
            SEG_5:   nibble = 4'h5;
            SEG_6:   nibble = 4'h6;
            SEG_7:   nibble = 4'h7;
            SEG_8:   nibble = 4'h8;
            SEG_9:   nibble = 4'h9;
            SEG_A:   nibble = 4'hA;
            SEG_B:   nibble = 4'hB;
            SEG_C:   nibble = 4'hC;
            SEG_D:   nibble = 4'hD;
            SEG_E:   nibble = 4'hE;
            SEG_F:   nibble = 4'hF;
            default: legal  = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_reader.sv
// seg_reader: observes the 16-bit seven-segment bus, commits a pattern once
// it has been stable, classifies it, and checks that successive valid
// values count down by one. Pure observer; never drives the display.
//   clk, rst (sync, active-low)
//   seg [15:0]       : [15:8] high digit byte, [7:0] low digit byte
//   clear            : zero step_count and err_count (wins over increments)
//   digit_hi/lo      : last committed legal digits
//   valid/blank/illegal/mismatch : classification of the last commit
//   update           : one-cycle pulse per commit
//   step_err         : pulse with update when the count-down step is wrong
//   step_count       : valid commits (wraps); err_count : step errors (sat.)
module seg_reader
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      seg,
    input  logic             clear,
    output logic [3:0]       digit_hi,
    output logic [3:0]       digit_lo,
    output logic             valid,
    output logic             blank,
    output logic             illegal,
    output logic             mismatch,
    output logic             update,
    output logic             step_err,
    output logic [CNT_W-1:0] step_count,
    output logic [7:0]       err_count
);

    localparam int STAB_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES - 1);

    logic [15:0]       seg_q, seg_d;
    logic [STAB_W-1:0] stab_q, stab_d;
    state_t            state_q, state_d;
    logic [15:0]       committed_q, committed_d;
    logic [3:0]        digit_hi_q, digit_hi_d, digit_lo_q, digit_lo_d;
    logic              valid_q, valid_d, blank_q, blank_d;
    logic              illegal_q, illegal_d, mismatch_q, mismatch_d;
    logic              update_q, update_d, step_err_q, step_err_d;
    logic [CNT_W-1:0]  step_count_q, step_count_d;
    logic [7:0]        err_count_q, err_count_d;

    logic       legal_hi, legal_lo, blank_hi, blank_lo;
    logic [3:0] nib_hi, nib_lo;
    logic [15:0] masked;
    logic       commit, new_valid, new_blank;
    logic [3:0] expected_lo;

    seg_byte_decode u_dec_hi (
        .seg_byte (seg_q[15:8]),
        .legal    (legal_hi),
        .blank    (blank_hi),
        .nibble   (nib_hi)
    );

    seg_byte_decode u_dec_lo (
        .seg_byte (seg_q[7:0]),
        .legal    (legal_lo),
        .blank    (blank_lo),
        .nibble   (nib_lo)
    );

    always_comb begin
        seg_d        = seg;
        stab_d       = stab_q;
        state_d      = state_q;
        committed_d  = committed_q;
        digit_hi_d   = digit_hi_q;
        digit_lo_d   = digit_lo_q;
        valid_d      = valid_q;
        blank_d      = blank_q;
        illegal_d    = illegal_q;
        mismatch_d   = mismatch_q;
        step_err_d   = 1'b0;
        step_count_d = step_count_q;
        err_count_d  = err_count_q;

        masked      = seg_q & {SEG_DP_MASK, SEG_DP_MASK};
        new_valid   = legal_hi & legal_lo;
        new_blank   = blank_hi & blank_lo;
        expected_lo = digit_lo_q - 4'd1;

        // seg != seg_q here means the value loaded into seg_q at this edge
        // differs from the one it replaces, so the stable run restarts.
        if (seg != seg_q) begin
            stab_d = '0;
        end else if (stab_q != STAB_MAX) begin
            stab_d = stab_q + 1'b1;
        end

        // Compare with dp masked so a dp-only flicker never re-commits.
        commit   = (stab_q == STAB_MAX) &&
                   ((state_q == IDLE) || (masked != committed_q));
        update_d = commit;

        if (commit) begin
            state_d     = TRACK;
            committed_d = masked;
            valid_d     = new_valid;
            blank_d     = new_blank;
            illegal_d   = !new_valid && !new_blank;
            mismatch_d  = new_valid && (nib_hi != nib_lo);
            if (new_valid) begin
                digit_hi_d = nib_hi;
                digit_lo_d = nib_lo;
            end
            // valid_q still describes the previous commit at this point.
            if ((state_q == TRACK) && valid_q && new_valid &&
                (nib_lo != expected_lo)) begin
                step_err_d = 1'b1;
            end
        end

        if (clear) begin
            step_count_d = '0;
        end else if (commit && new_valid) begin
            step_count_d = step_count_q + 1'b1;
        end

        if (clear) begin
            err_count_d = '0;
        end else if (step_err_d && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            // seg_q clears too, so the first sample after reset always
            // starts a fresh stable run.
            seg_q        <= '0;
            stab_q       <= '0;
            state_q      <= IDLE;
            committed_q  <= '0;
            digit_hi_q   <= '0;
            digit_lo_q   <= '0;
            valid_q      <= 1'b0;
            blank_q      <= 1'b0;
            illegal_q    <= 1'b0;
            mismatch_q   <= 1'b0;
            update_q     <= 1'b0;
            step_err_q   <= 1'b0;
            step_count_q <= '0;
            err_count_q  <= '0;
        end else begin
            seg_q        <= seg_d;
            stab_q       <= stab_d;
            state_q      <= state_d;
            committed_q  <= committed_d;
            digit_hi_q   <= digit_hi_d;
            digit_lo_q   <= digit_lo_d;
            valid_q      <= valid_d;
            blank_q      <= blank_d;
            illegal_q    <= illegal_d;
            mismatch_q   <= mismatch_d;
            update_q     <= update_d;
            step_err_q   <= step_err_d;
            step_count_q <= step_count_d;
            err_count_q  <= err_count_d;
        end
    end

    assign digit_hi   = digit_hi_q;
    assign digit_lo   = digit_lo_q;
    assign valid      = valid_q;
    assign blank      = blank_q;
    assign illegal    = illegal_q;
    assign mismatch   = mismatch_q;
    assign update     = update_q;
    assign step_err   = step_err_q;
    assign step_count = step_count_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_seg_reader.sv
// tb_seg_reader: table-driven bench with a scoreboard of expected commits.
module tb_seg_reader;

    localparam int STABLE_CYCLES = 4;
    localparam int CNT_W         = 16;

    logic             clk;
    logic             rst;
    logic [15:0]      seg;
    logic             clear;
    logic [3:0]       digit_hi, digit_lo;
    logic             valid, blank, illegal, mismatch, update, step_err;
    logic [CNT_W-1:0] step_count;
    logic [7:0]       err_count;

    seg_reader #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .CNT_W         (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .seg        (seg),
        .clear      (clear),
        .digit_hi   (digit_hi),
        .digit_lo   (digit_lo),
        .valid      (valid),
        .blank      (blank),
        .illegal    (illegal),
        .mismatch   (mismatch),
        .update     (update),
        .step_err   (step_err),
        .step_count (step_count),
        .err_count  (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  hi;
        logic [3:0]  lo;
        logic        v;
        logic        b;
        logic        il;
        logic        mm;
        logic        se;
        logic [15:0] sc;
        logic [7:0]  ec;
    } exp_t;

    typedef struct {
        logic [15:0] seg;
        int          hold;
        bit          upd;
        exp_t        e;
    } vec_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk_e(input logic [3:0] hi, input logic [3:0] lo,
                                  input bit v, input bit b, input bit il,
                                  input bit mm, input bit se,
                                  input int sc, input int ec);
        exp_t e;
        e.hi = hi; e.lo = lo; e.v = v; e.b = b; e.il = il; e.mm = mm;
        e.se = se; e.sc = 16'(sc); e.ec = 8'(ec);
        return e;
    endfunction

    function automatic vec_t mk_v(input logic [15:0] s, input int hold,
                                  input bit upd, input exp_t e);
        vec_t r;
        r.seg = s; r.hold = hold; r.upd = upd; r.e = e;
        return r;
    endfunction

    // Scoreboard side: every update pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            check("step_err_without_update", {31'd0, step_err & ~update}, 32'd0);
            if (update) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_update: got digits %0h/%0h expected no commit",
                             digit_hi, digit_lo);
                end else begin
                    e = sb.pop_front();
                    check("digit_hi",   {28'd0, digit_hi}, {28'd0, e.hi});
                    check("digit_lo",   {28'd0, digit_lo}, {28'd0, e.lo});
                    check("valid",      {31'd0, valid},    {31'd0, e.v});
                    check("blank",      {31'd0, blank},    {31'd0, e.b});
                    check("illegal",    {31'd0, illegal},  {31'd0, e.il});
                    check("mismatch",   {31'd0, mismatch}, {31'd0, e.mm});
                    check("step_err",   {31'd0, step_err}, {31'd0, e.se});
                    check("step_count", {16'd0, step_count}, {16'd0, e.sc});
                    check("err_count",  {24'd0, err_count},  {24'd0, e.ec});
                    $display("commit seg_q=%04h digits=%0h/%0h v=%0b b=%0b il=%0b mm=%0b se=%0b sc=%0d ec=%0d",
                             dut.seg_q, digit_hi, digit_lo, valid, blank, illegal,
                             mismatch, step_err, step_count, err_count);
                end
            end
        end
    end

    task automatic check_all_zero(input string name);
        check(name, {12'd0, digit_hi, digit_lo, valid, blank, illegal, mismatch,
                     update, step_err, err_count}, 32'd0);
        check({name, "_step_count"}, {16'd0, step_count}, 32'd0);
    endtask

    vec_t vecs[12];
    int   lat;

    initial begin
        rst   = 1'b0;
        clear = 1'b0;
        seg   = 16'hFCFC;

        // Reset held for 5 cycles: everything stays 0.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_all_zero("reset_outputs");
        end

        // Release and measure latency of the first commit.
        sb.push_back(mk_e(4'h0, 4'h0, 1, 0, 0, 0, 0, 1, 0));
        rst = 1'b1;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (update) begin
                lat = i;
                break;
            end
        end
        check("first_commit_latency", lat, STABLE_CYCLES + 1);
        @(posedge clk);
        #1;

        vecs[0]  = mk_v(16'h8E8E, 8, 1, mk_e(4'hF, 4'hF, 1, 0, 0, 0, 0, 2, 0));
        vecs[1]  = mk_v(16'h9E9E, 3, 0, mk_e(4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0));
        vecs[2]  = mk_v(16'h8E8E, 8, 0, mk_e(4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0));
        vecs[3]  = mk_v(16'h7A7A, 8, 1, mk_e(4'hD, 4'hD, 1, 0, 0, 0, 1, 3, 1));
        vecs[4]  = mk_v(16'h12FC, 8, 1, mk_e(4'hD, 4'hD, 0, 0, 1, 0, 0, 3, 1));
        vecs[5]  = mk_v(16'h0101, 8, 1, mk_e(4'hD, 4'hD, 0, 1, 0, 0, 0, 3, 1));
        vecs[6]  = mk_v(16'hFCFC, 8, 1, mk_e(4'h0, 4'h0, 1, 0, 0, 0, 0, 4, 1));
        vecs[7]  = mk_v(16'h6060, 8, 1, mk_e(4'h1, 4'h1, 1, 0, 0, 0, 1, 5, 2));
        vecs[8]  = mk_v(16'hFDFD, 8, 1, mk_e(4'h0, 4'h0, 1, 0, 0, 0, 0, 6, 2));
        vecs[9]  = mk_v(16'h00FC, 8, 1, mk_e(4'h0, 4'h0, 0, 0, 1, 0, 0, 6, 2));
        vecs[10] = mk_v(16'hFDFC, 8, 1, mk_e(4'h0, 4'h0, 1, 0, 0, 0, 0, 7, 2));
        vecs[11] = mk_v(16'hFCFC, 8, 0, mk_e(4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].upd) sb.push_back(vecs[i].e);
            seg = vecs[i].seg;
            repeat (vecs[i].hold) @(posedge clk);
            #1;
        end

        // clear asserted exactly in the cycle whose ending edge commits.
        sb.push_back(mk_e(4'h5, 4'h0, 1, 0, 0, 1, 1, 0, 0));
        seg = 16'hB6FC;
        repeat (STABLE_CYCLES) @(posedge clk);
        #1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Counting resumes after the clear.
        sb.push_back(mk_e(4'hF, 4'hF, 1, 0, 0, 0, 0, 1, 0));
        seg = 16'h8E8E;
        repeat (8) @(posedge clk);
        #1;

        // Reset mid-operation: next commit is a first commit again.
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("midreset_outputs");
        @(posedge clk);
        @(negedge clk);
        check_all_zero("midreset_outputs");
        sb.push_back(mk_e(4'hF, 4'hF, 1, 0, 0, 0, 0, 1, 0));
        rst = 1'b1;
        repeat (8) @(posedge clk);
        #1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seg_reader.md
# seg_reader

Monitors the 16-bit seven-segment drive bus produced by the countdown/display logic and turns it back into two hex digits. It requires each pattern to be stable before accepting it, flags blank and illegal patterns, and checks that successive committed values step down by one. It sits beside the display path as a self-check and observation block and never drives the display.

## Interface
Parameters:
- STABLE_CYCLES, 4, consecutive identical samples required before a pattern is committed (≥1)
- CNT_W, 16, width of step_count

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- seg  in  16  segment bus: [15:8] high digit, [7:0] low digit; per byte bit7..bit1 = a,b,c,d,e,f,g; bit0 = dp
- clear  in  1  synchronous clear of step_count and err_count
- digit_hi  out  4  last committed legal high digit
- digit_lo  out  4  last committed legal low digit
- valid  out  1  last commit had both bytes legal digits
- blank  out  1  last commit was 0x0000 (after dp mask)
- illegal  out  1  last commit was neither valid nor blank
- mismatch  out  1  valid and digit_hi != digit_lo
- update  out  1  one-cycle pulse on each commit
- step_err  out  1  one-cycle pulse, coincident with update, when the step check fails
- step_count  out  CNT_W  number of valid commits, wraps
- err_count  out  8  number of step_err pulses, saturates at 255

## Operation
- Per-byte decode masks dp (bit0 ignored). Legal patterns are 0 FC, 1 60, 2 DA, 3 F2, 4 66, 5 B6, 6 BE, 7 E0, 8 FE, 9 F6, A EE, B 3E, C 9C, D 7A, E 9E, F 8E. Byte 00 is blank. Any other byte is illegal.
- Input register: seg is registered into seg_q every cycle.
- Stability counter: resets to 0 whenever seg_q differs from its previous value and saturates at STABLE_CYCLES-1.
- Commit condition: the counter reaches its limit AND (state is IDLE OR the masked seg_q differs from the committed pattern).
- On commit:
  - The pattern is latched and classification outputs are updated.
  - digit_hi/digit_lo update only when valid. Otherwise they hold.
  - update pulses.
- States:
  - IDLE: no commit since reset. The first commit moves the block to TRACK and performs no step check.
  - TRACK: stays in TRACK until reset.
- Step check (TRACK only, current and previous commit both valid):
  - expected = (previous digit_lo − 1) mod 16.
  - On mismatch: step_err pulses and err_count increments, saturating.
  - A commit following a blank or illegal commit is not checked.
- step_count increments on every valid commit, including the first, and wraps at 2^CNT_W.
- clear has priority over increments in the same cycle. The commit itself still proceeds.

## Timing
- Reset: all outputs are 0, state is IDLE, and the stability counter is 0.
- Latency: a new seg value first sampled into seg_q at edge n is committed at edge n+STABLE_CYCLES. update is high for the one cycle after that edge.
- Glitch rejection: a value held for fewer than STABLE_CYCLES samples is never committed.
- Reset mid-operation: all stability history is discarded, and the next commit is treated as the first one.
- A pattern that changes back to the committed value before becoming stable produces no update.

## Structure
- Package seg_pkg holds:
  - the 16 pattern constants SEG_0..SEG_F
  - SEG_BLANK
  - SEG_DP_MASK
  - the state enum {IDLE, TRACK}
- Sub-module seg_byte_decode is combinational: 8-bit byte in → {legal, blank, nibble}. It is instantiated twice.
- The top level holds the input register, the stability counter, the FSM, the step checker and the counters.

## Test plan
- Hold rst=0 for 5 cycles with seg=0xFCFC → every output is 0 throughout.
- Release reset, hold seg=0xFCFC → update pulses 5 cycles after release with digits 0/0, valid=1, step_count=1, step_err=0. Then seg=0x8E8E → digits F/F, no step_err, step_count=2.
- From committed 0x8E8E, drive 0x9E9E for 3 cycles, then back to 0x8E8E (STABLE_CYCLES=4) → no update pulse, digits remain F.
- Commit F, then 0x7A7A (D) → update with step_err pulse, err_count=1, digits D/D.
- seg=0x12FC → illegal=1, valid=0, digits hold. Then seg=0x0101 → blank=1 (dp masked). Then seg=0xFCFC → valid, with no step check.
- seg=0xFDFD decodes to 0/0 (dp ignored). seg=0xB6FC → mismatch=1. Assert clear in the update cycle → step_count=0 and err_count=0, while the digits still update.
